// File: rtl/grid_world_env_pkg.sv
// Shared types and constants for the 8x8 grid-world environment.
// Cells are encoded row*8+col; rewards are 16-bit two's complement.
package rl_env_pkg;

  localparam int GRID_DIM = 8;

  typedef logic [5:0] state_t;

  localparam logic [3:0] ACT_UP    = 4'b0001;
  localparam logic [3:0] ACT_DOWN  = 4'b0010;
  localparam logic [3:0] ACT_LEFT  = 4'b0100;
  localparam logic [3:0] ACT_RIGHT = 4'b1000;

  localparam logic signed [15:0] R_STEP = -16'sd1;
  localparam logic signed [15:0] R_WALL = -16'sd10;
  localparam logic signed [15:0] R_GOAL = 16'sd100;

  typedef enum logic [1:0] {
    RC_STEP,
    RC_WALL,
    RC_GOAL
  } rclass_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_MOVE,
    ST_REPORT
  } fsm_t;

  function automatic logic signed [15:0] reward_of(rclass_t c);
    case (c)
      RC_GOAL: return R_GOAL;
      RC_WALL: return R_WALL;
      default: return R_STEP;
    endcase
  endfunction

endpackage

// File: rtl/grid_world_env_if.sv
// Agent <-> environment bus: control inputs, action handshake and observation outputs.
interface grid_world_env_if;
  import rl_env_pkg::*;

  logic        en;
  logic        start;
  logic        action_valid;
  logic [3:0]  action;
  logic        action_ready;
  logic        obs_valid;
  state_t      next_state;
  logic [15:0] next_reward;
  logic        done;
  logic [15:0] episode_count;
  logic [15:0] step_count;

  modport master (
    output en, start, action_valid, action,
    input  action_ready, obs_valid, next_state, next_reward, done,
           episode_count, step_count
  );

  modport slave (
    input  en, start, action_valid, action,
    output action_ready, obs_valid, next_state, next_reward, done,
           episode_count, step_count
  );

endinterface

// File: rtl/grid_world_env_move_calc.sv
// Combinational move resolver: current cell + action -> target cell and reward class.
// Blocked moves (bad action, grid edge, wall) leave the agent where it is.
module grid_move_calc
  import rl_env_pkg::*;
#(
  parameter state_t      GOAL_STATE = 6'd63,
  parameter logic [63:0] WALL_MASK  = 64'h0
) (
  input  state_t     i_cur_state,
  input  logic [3:0] i_action,
  output state_t     o_target,
  output rclass_t    o_rclass
);

  logic [2:0] w_row;
  logic [2:0] w_col;
  logic       w_blocked;
  state_t     w_cand;

  assign w_row = i_cur_state[5:3];
  assign w_col = i_cur_state[2:0];

  always_comb begin
    w_cand    = i_cur_state;
    w_blocked = 1'b0;
    case (i_action)
      ACT_UP: begin
        if (w_row == 3'd0) w_blocked = 1'b1;
        else               w_cand    = {w_row - 3'd1, w_col};
      end
      ACT_DOWN: begin
        if (w_row == 3'(GRID_DIM - 1)) w_blocked = 1'b1;
        else                           w_cand    = {w_row + 3'd1, w_col};
      end
      ACT_LEFT: begin
        if (w_col == 3'd0) w_blocked = 1'b1;
        else               w_cand    = {w_row, w_col - 3'd1};
      end
      ACT_RIGHT: begin
        if (w_col == 3'(GRID_DIM - 1)) w_blocked = 1'b1;
        else                           w_cand    = {w_row, w_col + 3'd1};
      end
      default: w_blocked = 1'b1;
    endcase
    if (WALL_MASK[w_cand]) w_blocked = 1'b1;
  end

  always_comb begin
    o_target = i_cur_state;
    o_rclass = RC_WALL;
    if (!w_blocked) begin
      o_target = w_cand;
      o_rclass = (w_cand == GOAL_STATE) ? RC_GOAL : RC_STEP;
    end
  end

endmodule

// File: rtl/grid_world_env.sv
// Grid-world RL environment: episode FSM, step/episode counters and observation registers.
//   state  | meaning
//   IDLE   | no episode running, waiting for start
//   READY  | episode running, action_ready offered
//   MOVE   | latched action being resolved into the observation registers
//   REPORT | obs_valid pulse; returns to IDLE when done, else READY
module grid_world_env
  import rl_env_pkg::*;
#(
  parameter state_t      START_STATE = 6'd0,
  parameter state_t      GOAL_STATE  = 6'd63,
  parameter logic [63:0] WALL_MASK   = 64'h0,
  parameter logic [15:0] MAX_STEPS   = 16'd256
) (
  input logic             clk,
  input logic             rst_n,
  grid_world_env_if.slave bus
);

  if (START_STATE == GOAL_STATE || WALL_MASK[START_STATE] || WALL_MASK[GOAL_STATE])
  begin : g_bad_cfg
    $error("grid_world_env: START_STATE/GOAL_STATE/WALL_MASK combination is illegal");
  end

  fsm_t              r_state;
  fsm_t              w_state_nxt;
  state_t            r_cur_state;
  logic signed [15:0] r_reward;
  logic              r_done;
  logic [15:0]       r_episode_count;
  logic [15:0]       r_step_count;
  logic [3:0]        r_action;
  state_t            w_target;
  rclass_t           w_rclass;
  logic              w_ready;
  logic              w_accept;
  logic              w_restart;

  grid_move_calc #(
    .GOAL_STATE (GOAL_STATE),
    .WALL_MASK  (WALL_MASK)
  ) u_move_calc (
    .i_cur_state (r_cur_state),
    .i_action    (r_action),
    .o_target    (w_target),
    .o_rclass    (w_rclass)
  );

  assign w_restart = bus.en & bus.start;
  assign w_ready   = (r_state == ST_READY) & bus.en & ~bus.start;
  assign w_accept  = bus.action_valid & w_ready;

  assign bus.action_ready  = w_ready;
  assign bus.obs_valid     = (r_state == ST_REPORT) & bus.en;
  assign bus.next_state    = r_cur_state;
  assign bus.next_reward   = r_reward;
  assign bus.done          = r_done;
  assign bus.episode_count = r_episode_count;
  assign bus.step_count    = r_step_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = ST_REPORT;
    end else if (bus.en) begin
      case (r_state)
        ST_READY:  if (w_accept) w_state_nxt = ST_MOVE;
        ST_MOVE:   w_state_nxt = ST_REPORT;
        ST_REPORT: w_state_nxt = r_done ? ST_IDLE : ST_READY;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // The observation register doubles as the agent's current cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_state     <= START_STATE;
      r_reward        <= '0;
      r_done          <= 1'b0;
      r_episode_count <= '0;
      r_step_count    <= '0;
      r_action        <= '0;
    end else if (w_restart) begin
      r_cur_state  <= START_STATE;
      r_reward     <= '0;
      r_done       <= 1'b0;
      r_step_count <= '0;
    end else if (bus.en) begin
      if (w_accept) begin
        r_action     <= bus.action;
        r_step_count <= r_step_count + 16'd1;
      end
      if (r_state == ST_MOVE) begin
        r_cur_state <= w_target;
        r_reward    <= reward_of(w_rclass);
        r_done      <= (w_rclass == RC_GOAL) || (r_step_count == MAX_STEPS);
      end
      if (r_state == ST_REPORT && r_done && r_episode_count != 16'hFFFF)
        r_episode_count <= r_episode_count + 16'd1;
    end
  end

endmodule

// File: doc/grid_world_env.md
GRID_WORLD_ENV -- requirements
Module: grid_world_env

Interface
REQ-001 Parameter START_STATE, default 6'd0: cell the agent occupies at episode start.
REQ-002 Parameter GOAL_STATE, default 6'd63: terminal cell.
REQ-003 Parameter WALL_MASK, default 64'h0: bit i=1 marks cell i as blocked.
REQ-004 Parameter MAX_STEPS, default 16'd256: accepted actions per episode before timeout.
REQ-005 clk  in  1  single clock; all state rises on posedge clk.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  global enable; when low, FSM, counters and outputs SHALL hold.
REQ-008 start  in  1  begin a new episode.
REQ-009 action_valid  in  1  agent presents an action.
REQ-010 action  in  4  one-hot move: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-011 action_ready  out  1  environment accepts the action this cycle.
REQ-012 obs_valid  out  1  one-cycle pulse marking a new observation.
REQ-013 next_state  out  6  agent cell after the move, encoded row*8+col.
REQ-014 next_reward  out  16  signed reward for the move.
REQ-015 done  out  1  the observation ends the episode.
REQ-016 episode_count  out  16  completed episodes, saturating at 16'hFFFF.
REQ-017 step_count  out  16  actions accepted in the current episode.

Function
REQ-018 FSM states: IDLE, READY, MOVE, REPORT.
REQ-019 IDLE: on start&en, load cur_state=START_STATE, clear step_count, stage reward 0, go to REPORT.
REQ-020 action_ready = (FSM==READY) & en & ~start; acceptance = action_valid & action_ready; go to MOVE.
REQ-021 MOVE: compute the target cell and reward per REQ-023..026, then go to REPORT.
REQ-022 REPORT: drive obs_valid=1 for exactly one en-high cycle; next state is IDLE if done, else READY; action accepted at cycle N yields obs_valid at N+2.
REQ-023 An action that is not exactly one-hot SHALL cause no move and reward R_WALL (-10).
REQ-024 A target off-grid (row/col under- or overflow; no wrap-around) or with WALL_MASK[target]=1 SHALL cause no move and reward R_WALL.
REQ-025 A target equal to GOAL_STATE SHALL move the agent, give reward R_GOAL (+100), and set done=1.
REQ-026 Any other legal target SHALL move the agent and give reward R_STEP (-1).
REQ-027 step_count increments on each acceptance; a non-goal observation with step_count==MAX_STEPS SHALL set done=1 (timeout) and keep that move's reward.
REQ-028 episode_count increments in the REPORT cycle that carries done=1, saturating at 16'hFFFF.
REQ-029 start in READY, MOVE or REPORT SHALL abandon the episode: no episode_count increment; behaviour then matches REQ-019; start in the same cycle as action_valid wins.
REQ-030 next_state, next_reward and done SHALL hold their values between obs_valid pulses; done clears at the next start.
REQ-031 Elaboration SHALL fail if START_STATE==GOAL_STATE or WALL_MASK marks START_STATE or GOAL_STATE.

Reset
REQ-032 rst_n low SHALL force: FSM=IDLE, action_ready=0, obs_valid=0, next_state=START_STATE, next_reward=0, done=0, episode_count=0, step_count=0.
REQ-033 Reset mid-episode SHALL discard the episode; no observation is emitted until the next start.

Structure
REQ-034 Package rl_env_pkg SHALL hold GRID_DIM=8, the state typedef (6 bit), one-hot action constants, and R_STEP, R_WALL, R_GOAL as 16-bit signed constants.
REQ-035 Sub-module grid_move_calc (combinational: cur_state, action -> target, reward class) SHALL hold the move logic; the FSM and counters stay in grid_world_env.

Verification
REQ-036 Reset, then start -> one obs_valid pulse with next_state=0, reward=0; action_ready=1 the cycle after.
REQ-037 At state 0, action 4'b0010 -> obs_valid two cycles after acceptance, next_state=8, next_reward=16'hFFFF.
REQ-038 At state 0, action 4'b0001, then 4'b0011 -> next_state=0 and next_reward=16'hFFF6 both times.
REQ-039 At state 62, action 4'b1000 -> next_state=63, reward=100, done=1, episode_count=1, FSM IDLE, action_ready=0.
REQ-040 MAX_STEPS=4, four up-bumps from state 0 -> done=1 on the fourth obs_valid, episode_count=1.
REQ-041 start after three moves -> next_state=START_STATE, step_count=0, episode_count unchanged; start with action_valid high -> action not accepted.
